// File: rtl/spi_controller_if.sv
// rtl/spi_controller_if.sv - command and SPI pin bundle for spi_controller; SPI_READBACK_EN adds cmd_write/cipo/rd_data
interface spi_controller_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       busy;
   logic       done;
   logic       sclk;
   logic       ncs;
   logic       copi;
`ifdef SPI_READBACK_EN
   logic       cmd_write;
   logic       cipo;
   logic [7:0] rd_data;
`endif

   modport master (
      input  cmd_valid, cmd_addr, cmd_data,
      output cmd_ready, busy, done, sclk, ncs, copi
`ifdef SPI_READBACK_EN
      , input cmd_write, cipo
      , output rd_data
`endif
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_data,
      input  cmd_ready, busy, done, sclk, ncs, copi
`ifdef SPI_READBACK_EN
      , output cmd_write, cipo
      , input rd_data
`endif
   );
endinterface

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 initiator sending 16-bit register frames, MSB first
// Optional SPI_READBACK_EN: bit15 from cmd_write, cipo captured on bits 8..15 into rd_data.
module spi_controller #(
   parameter int CLK_DIV = 4,
   parameter int GAP_CYC = 4
) (
   input logic              clk,
   input logic              rst,
   spi_controller_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD, S_GAP} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_div;
   logic [7:0]  w_div_nxt;
   logic [4:0]  r_bit_cnt;
   logic [4:0]  w_bit_cnt_nxt;
   logic [15:0] r_shift;
   logic [15:0] w_shift_nxt;
   logic        r_sclk;
   logic        r_ncs;
   logic        r_copi;
   logic        r_done;
   logic        r_busy;
   logic        r_cmd_ready;
   logic        w_accept;
   logic        w_div_last;
   logic        w_bit_end;
   logic        w_frame_end;
   logic        w_frame_bit15;
   logic        w_copi_nxt;

`ifdef SPI_READBACK_EN
   assign w_frame_bit15 = bus.cmd_write;
`else
   assign w_frame_bit15 = 1'b1;
`endif

   assign w_accept    = (r_state == S_IDLE) && bus.cmd_valid;
   assign w_div_last  = (r_div == DIV_LAST);
   assign w_bit_end   = (r_state == S_HIGH) && w_div_last;
   assign w_frame_end = (r_state == S_HOLD) && w_div_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // r_div times every phase; it restarts at zero on each state change.
   always_comb begin
      w_state_nxt   = r_state;
      w_div_nxt     = r_div + 8'd1;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      case (r_state)
         S_IDLE: begin
            w_div_nxt = 8'd0;
            if (w_accept) begin
               w_state_nxt   = S_LOW;
               w_bit_cnt_nxt = 5'd0;
               w_shift_nxt   = {w_frame_bit15, bus.cmd_addr, bus.cmd_data};
            end
         end
         S_LOW: begin
            if (w_div_last) begin
               w_state_nxt = S_HIGH;
               w_div_nxt   = 8'd0;
            end
         end
         S_HIGH: begin
            if (w_div_last) begin
               w_div_nxt   = 8'd0;
               w_shift_nxt = {r_shift[14:0], 1'b0};
               if (r_bit_cnt != 5'd16) begin
                  w_bit_cnt_nxt = r_bit_cnt + 5'd1;
               end
               w_state_nxt = (r_bit_cnt == 5'd15) ? S_HOLD : S_LOW;
            end
         end
         S_HOLD: begin
            if (w_div_last) begin
               w_state_nxt = S_GAP;
               w_div_nxt   = 8'd0;
            end
         end
         S_GAP: begin
            if (r_div == GAP_LAST) begin
               w_state_nxt = S_IDLE;
               w_div_nxt   = 8'd0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_div_nxt   = 8'd0;
         end
      endcase

      // copi only moves on entry to LOW (sclk low or falling); it is parked at 0 outside the frame.
      w_copi_nxt = 1'b0;
      case (w_state_nxt)
         S_LOW:          w_copi_nxt = w_shift_nxt[15];
         S_HIGH, S_HOLD: w_copi_nxt = r_copi;
         default:        w_copi_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div       <= 8'd0;
         r_bit_cnt   <= 5'd0;
         r_shift     <= 16'd0;
         r_sclk      <= 1'b0;
         r_ncs       <= 1'b1;
         r_copi      <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_cmd_ready <= 1'b1;
      end else begin
         r_div       <= w_div_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_sclk      <= (w_state_nxt == S_HIGH);
         r_ncs       <= !(w_state_nxt inside {S_LOW, S_HIGH, S_HOLD});
         r_copi      <= w_copi_nxt;
         r_done      <= w_frame_end;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_cmd_ready <= (w_state_nxt == S_IDLE);
      end
   end

   assign bus.sclk      = r_sclk;
   assign bus.ncs       = r_ncs;
   assign bus.copi      = r_copi;
   assign bus.done      = r_done;
   assign bus.busy      = r_busy;
   assign bus.cmd_ready = r_cmd_ready;

`ifdef SPI_READBACK_EN
   logic [7:0] r_rx;
   logic [7:0] r_rd_data;
   logic       r_is_write;

   // cipo is taken in the final HIGH cycle, just before sclk falls, for the data byte only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx       <= 8'd0;
         r_rd_data  <= 8'd0;
         r_is_write <= 1'b0;
      end else begin
         if (w_accept) begin
            r_is_write <= bus.cmd_write;
         end
         if (w_bit_end && (r_bit_cnt >= 5'd8)) begin
            r_rx <= {r_rx[6:0], bus.cipo};
         end
         if (w_frame_end && !r_is_write) begin
            r_rd_data <= r_rx;
         end
      end
   end

   assign bus.rd_data = r_rd_data;
`endif
endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - scoreboard bench for spi_controller (CLK_DIV=2 main instance, CLK_DIV=1 side instance)
module tb_spi_controller;
   localparam int CD    = 2;
   localparam int GAP   = 4;
   localparam int CD_B  = 1;
   localparam int GAP_B = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_controller_if bus_a();
   spi_controller_if bus_b();

   spi_controller #(.CLK_DIV(CD), .GAP_CYC(GAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   spi_controller #(.CLK_DIV(CD_B), .GAP_CYC(GAP_B)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] sb_q[$];
   logic [7:0]  model_regs[128];
   logic [7:0]  mon_regs[128];
   int          frames_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Frame monitor: rebuilds each frame from the pins and checks it against the scoreboard on done.
   int          m_rises, m_low, m_high;
   logic [15:0] m_rx;
   logic        m_prev_sclk, m_prev_copi, m_bad_copi, m_bad_ready;
   logic [15:0] m_exp;

   always @(negedge clk) begin
      if (rst) begin
         m_rises = 0; m_low = 0; m_high = 1000; m_rx = '0;
         m_prev_sclk = 1'b0; m_prev_copi = 1'b0; m_bad_copi = 1'b0; m_bad_ready = 1'b0;
      end else begin
         if (bus_a.ncs == 1'b0) begin
            if (m_low == 0) chk("gap_before_frame", 32'(m_high >= GAP), 1);
            m_low++;
            m_high = 0;
            if (bus_a.cmd_ready) m_bad_ready = 1'b1;
            if (bus_a.sclk && !m_prev_sclk) begin
               m_rises++;
               m_rx = {m_rx[14:0], bus_a.copi};
            end
            if (bus_a.sclk && (bus_a.copi != m_prev_copi)) m_bad_copi = 1'b1;
         end else begin
            m_high++;
            if (bus_a.copi || bus_a.sclk) m_bad_copi = 1'b1;
         end
         if (bus_a.done) begin
            frames_done++;
            chk("done_has_expected", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               m_exp = sb_q.pop_front();
               chk("frame_bits", m_rx, m_exp);
               chk("sclk_rises", m_rises, 16);
               chk("ncs_low_cycles", m_low, 33 * CD);
               chk("copi_rules", m_bad_copi, 0);
               chk("ready_low_in_frame", m_bad_ready, 0);
               if (m_rx[15]) mon_regs[m_rx[14:8]] = m_rx[7:0];
            end
            m_rises = 0; m_low = 0; m_rx = '0; m_bad_copi = 1'b0; m_bad_ready = 1'b0;
         end
         m_prev_sclk = bus_a.sclk;
         m_prev_copi = bus_a.copi;
      end
   end

   logic b_prev_copi = 1'b0;
   always @(negedge clk) begin
      if (!rst && bus_b.sclk) chk("b_copi_stable_while_sclk_high", bus_b.copi, b_prev_copi);
      b_prev_copi = bus_b.copi;
   end

`ifdef SPI_READBACK_EN
   logic [7:0] rb_val = 8'd0;
   always @(negedge clk) begin
      if (rst || bus_a.ncs) bus_a.cipo = 1'b0;
      else if (!bus_a.sclk) bus_a.cipo = (m_rises >= 8 && m_rises < 16) ? rb_val[15 - m_rises] : 1'b0;
   end
`endif

   task automatic issue(input logic [6:0] a, input logic [7:0] d, input logic wr,
                        input bit expect_frame, input bit keep_valid);
      int n = 0;
      bus_a.cmd_addr  = a;
      bus_a.cmd_data  = d;
`ifdef SPI_READBACK_EN
      bus_a.cmd_write = wr;
`endif
      bus_a.cmd_valid = 1'b1;
      while (!bus_a.cmd_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         checks++; errors++;
         $display("FAIL issue_ready_timeout actual=%0d required<5000", n);
      end
      if (expect_frame) begin
         sb_q.push_back({wr, a, d});
         if (wr) model_regs[a] = d;
      end
      @(negedge clk);
      if (!keep_valid) bus_a.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb_q.size() != 0 || !bus_a.cmd_ready) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         checks++; errors++;
         $display("FAIL wait_idle_timeout queue=%0d ready=%0b required queue=0 ready=1", sb_q.size(), bus_a.cmd_ready);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=expired required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, f0, bad, rises, low, toggles, n;
      logic prev_s;
      logic [15:0] rx;

      for (int i = 0; i < 128; i++) begin
         model_regs[i] = 8'd0;
         mon_regs[i]   = 8'd0;
      end
      rst = 1'b1;
      bus_a.cmd_valid = 1'b0; bus_a.cmd_addr = '0; bus_a.cmd_data = '0;
      bus_b.cmd_valid = 1'b0; bus_b.cmd_addr = '0; bus_b.cmd_data = '0;
`ifdef SPI_READBACK_EN
      bus_a.cmd_write = 1'b1;
      bus_b.cmd_write = 1'b1; bus_b.cipo = 1'b0;
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_cmd_ready", bus_a.cmd_ready, 1);
      chk("rst_busy", bus_a.busy, 0);
      chk("rst_done", bus_a.done, 0);
      chk("rst_sclk", bus_a.sclk, 0);
      chk("rst_ncs", bus_a.ncs, 1);
      chk("rst_copi", bus_a.copi, 0);
`ifdef SPI_READBACK_EN
      chk("rst_rd_data", bus_a.rd_data, 0);
`endif

      // Directed write: frame 0x8480, latency to ready 1 + 33*CD + GAP.
      f0 = frames_done;
      issue(7'h04, 8'h80, 1'b1, 1'b1, 1'b0);
      chk("ncs_fall_after_accept", bus_a.ncs, 0);
      chk("busy_after_accept", bus_a.busy, 1);
      chk("ready_low_after_accept", bus_a.cmd_ready, 0);
      lat = 1;
      while (!bus_a.cmd_ready && lat < 500) begin
         @(negedge clk);
         lat++;
      end
      chk("accept_to_ready", lat, 1 + 33 * CD + GAP);
      chk("busy_clear_with_ready", bus_a.busy, 0);
      wait_idle();
      chk("directed_done_count", frames_done - f0, 1);

      issue(7'h00, 8'hA5, 1'b1, 1'b1, 1'b0); wait_idle();
      issue(7'h01, 8'h3C, 1'b1, 1'b1, 1'b0); wait_idle();
      issue(7'h04, 8'h7F, 1'b1, 1'b1, 1'b0); wait_idle();
      chk("reg_00", mon_regs[0], 8'hA5);
      chk("reg_01", mon_regs[1], 8'h3C);
      chk("reg_04", mon_regs[4], 8'h7F);

      // cmd_valid held high across three commands.
      f0 = frames_done;
      for (int i = 0; i < 3; i++) begin
         issue(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b1);
      end
      bus_a.cmd_valid = 1'b0;
      wait_idle();
      chk("held_valid_frames", frames_done - f0, 3);

      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         issue(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0);
      end
      wait_idle();
      bad = 0;
      for (int i = 0; i < 128; i++) if (mon_regs[i] !== model_regs[i]) bad++;
      chk("reg_file_mismatches", bad, 0);

      // Reset during the 9th HIGH phase.
      f0 = frames_done;
      issue(7'h05, 8'h11, 1'b1, 1'b0, 1'b0);
      rises = 0; prev_s = bus_a.sclk; n = 0;
      while (rises < 9 && n < 1000) begin
         @(negedge clk);
         n++;
         if (bus_a.sclk && !prev_s) rises++;
         prev_s = bus_a.sclk;
      end
      chk("reached_9th_high", rises, 9);
      rst = 1'b1;
      #1;
      chk("abort_sclk", bus_a.sclk, 0);
      chk("abort_ncs", bus_a.ncs, 1);
      chk("abort_copi", bus_a.copi, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      chk("abort_no_done", frames_done - f0, 0);
      chk("abort_reg_unchanged", mon_regs[5], model_regs[5]);
      issue(7'h05, 8'h22, 1'b1, 1'b1, 1'b0);
      wait_idle();
      chk("after_abort_reg", mon_regs[5], 8'h22);

`ifdef SPI_READBACK_EN
      rb_val = 8'h5A;
      issue(7'h02, 8'h00, 1'b0, 1'b1, 1'b0);
      wait_idle();
      chk("readback_data", bus_a.rd_data, 8'h5A);
      rb_val = 8'hFF;
      issue(7'h03, 8'h99, 1'b1, 1'b1, 1'b0);
      wait_idle();
      chk("readback_hold_on_write", bus_a.rd_data, 8'h5A);
`endif

      // CLK_DIV=1 instance: one frame, sclk toggling every cycle.
      @(negedge clk);
      bus_b.cmd_addr = 7'h2A; bus_b.cmd_data = 8'hC3; bus_b.cmd_valid = 1'b1;
      @(negedge clk);
      bus_b.cmd_valid = 1'b0;
      rises = 0; low = 0; toggles = 0; rx = '0; prev_s = 1'b0; n = 1;
      while (!bus_b.done && n < 300) begin
         if (!bus_b.ncs) begin
            low++;
            if (bus_b.sclk != prev_s) toggles++;
            if (bus_b.sclk && !prev_s) begin
               rises++;
               rx = {rx[14:0], bus_b.copi};
            end
         end
         prev_s = bus_b.sclk;
         @(negedge clk);
         n++;
      end
      chk("b_done_seen", bus_b.done, 1);
      chk("b_ncs_low_cycles", low, 33 * CD_B);
      chk("b_rises", rises, 16);
      chk("b_toggles", toggles, 32);
      chk("b_frame", rx, {1'b1, 7'h2A, 8'hC3});
      while (!bus_b.cmd_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("b_accept_to_ready", n, 1 + 33 * CD_B + GAP_B);

      repeat (5) @(negedge clk);
      chk("queue_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
